accel_host_seq: RTL and testbench

ACCEL_HOST_SEQ -- requirements
Module: accel_host_seq

---
 rtl/accel_host_seq.sv | 125 ++++++++++++
 tb/tb_accel_host_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/accel_host_seq.sv
// Host-side sequencer for a single-job accelerator: queues operands in a FIFO,
// issues them one at a time, captures each result (or a timeout) for a consumer.
module accel_host_seq #(
  parameter int XW      = 8,
  parameter int RW      = 16,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [XW-1:0]            in_x,
  output logic                     in_ready,
  output logic                     acc_start,
  output logic [XW-1:0]            acc_x,
  input  logic                     acc_ready,
  input  logic [RW-1:0]            acc_result,
  output logic                     out_valid,
  output logic [RW-1:0]            out_result,
  output logic                     out_err,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, OUTPUT} state_e;

  state_e          state_q, state_d;
  logic [XW-1:0]   mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [XW-1:0]   accx_q, accx_d;
  logic [RW-1:0]   res_q, res_d;
  logic            err_q, err_d;
  logic            push, pop, tmo_hit;

  // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
  assign in_ready = (cnt_q != FULL_CNT);
  assign push     = in_valid && in_ready;
  assign pop      = (state_q == IDLE) && (cnt_q != '0) && acc_ready;
  assign cnt_d    = cnt_q + CW'(push) - CW'(pop);
  // Reaching TIMEOUT after this cycle's increment ends the job.
  assign tmo_hit  = (tmo_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= in_x;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      accx_q  <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      accx_q  <= accx_d;
      res_q   <= res_d;
      err_q   <= err_d;
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    accx_d    = accx_q;
    res_d     = res_q;
    err_d     = err_q;
    acc_start = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          accx_d  = mem_q[rptr_q];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        acc_start = 1'b1;
        tmo_d     = '0;
        state_d   = WAIT_BUSY;
      end
      WAIT_BUSY, WAIT_DONE: begin
        tmo_d = tmo_q + TW'(1);
        // Timeout wins over an acc_ready edge arriving in the same cycle.
        if (tmo_hit) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = OUTPUT;
        end else if (state_q == WAIT_BUSY) begin
          if (!acc_ready) state_d = WAIT_DONE;
        end else if (acc_ready) begin
          res_d   = acc_result;
          err_d   = 1'b0;
          state_d = OUTPUT;
        end
      end
      OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign acc_x      = accx_q;
  assign out_result = res_q;
  assign out_err    = err_q;
  assign fifo_count = cnt_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_accel_host_seq.sv
// Bench for accel_host_seq: accelerator responder, queue-based scoreboard,
// table of single jobs, hand-written corner sequences and a random phase.
module tb_accel_host_seq;
  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [7:0]  in_x;
  logic        acc_start, acc_ready;
  logic [7:0]  acc_x;
  logic [15:0] acc_result;
  logic        out_valid, out_err, out_ready;
  logic [15:0] out_result;
  logic [2:0]  fifo_count;
  logic        busy;

  int total = 0, bad = 0;

  accel_host_seq #(.XW(8), .RW(16), .DEPTH(4), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_x(in_x), .in_ready(in_ready),
    .acc_start(acc_start), .acc_x(acc_x), .acc_ready(acc_ready), .acc_result(acc_result),
    .out_valid(out_valid), .out_result(out_result), .out_err(out_err), .out_ready(out_ready),
    .fifo_count(fifo_count), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Accelerator: result = x*mul + add after acc_lat busy cycles; hang ignores starts.
  int          acc_lat = 3;
  bit          acc_hang = 0, rand_lat = 0;
  logic [15:0] mul = 16'd2, add = 16'd0;
  int          bcnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_ready  <= 1'b1;
      acc_result <= '0;
      bcnt       <= 0;
    end else if (bcnt != 0) begin
      bcnt <= bcnt - 1;
      if (bcnt == 1) begin
        acc_ready  <= 1'b1;
        acc_result <= 16'(acc_x) * mul + add;
      end
    end else if (acc_start && !acc_hang) begin
      acc_ready  <= 1'b0;
      acc_result <= 16'hDEAD;
      bcnt       <= rand_lat ? int'($urandom_range(1, 12)) : acc_lat;
    end
  end

  // Scoreboard: operands accepted in order, one job in flight at a time.
  logic [7:0]  q[$];
  bit          pend, hold, seen, exp_err;
  logic [15:0] exp_res, prev_res;
  int          cyc = 0, st_cyc = 0, outv_cnt = 0;
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      q.delete();
      pend = 0; hold = 0; seen = 0;
    end else begin
      if (out_valid) outv_cnt++;
      if (acc_start) begin
        chk("start_while_pending", pend, 0);
        if (q.size() == 0) chk("spurious_start", acc_start, 0);
        else begin
          chk("acc_x_order", acc_x, q[0]);
          exp_err = acc_hang;
          exp_res = acc_hang ? 16'h0 : 16'(q[0]) * mul + add;
          void'(q.pop_front());
        end
        pend = 1; seen = 0; st_cyc = cyc;
      end
      chk("fifo_count", fifo_count, q.size());
      chk("in_ready", in_ready, q.size() != 4);
      chk("busy", busy, pend);
      if (out_valid) begin
        chk("out_valid_no_job", pend, 1);
        if (!seen) begin
          seen = 1;
          if (exp_err) chk("timeout_cycles", cyc - st_cyc, 256);
        end
        if (hold) chk("out_hold", out_result, prev_res);
        chk("out_result", out_result, exp_res);
        chk("out_err", out_err, exp_err);
        if (out_ready) begin pend = 0; hold = 0; end
        else begin hold = 1; prev_res = out_result; end
      end
      if (in_valid && in_ready) q.push_back(in_x);
    end
  end

  task automatic push(input logic [7:0] x);
    int n = 0;
    in_valid = 1'b1; in_x = x;
    @(negedge clk);
    while (!in_ready && n < 2000) begin @(negedge clk); n++; end
    chk("push_accept_bound", n < 2000, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic get_out(output logic [15:0] r, output logic e);
    int n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 3000);
    chk("out_wait_bound", n < 3000, 1);
    r = out_result; e = out_err;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while ((q.size() != 0 || pend || busy) && n < 5000);
    chk("idle_wait_bound", n < 5000, 1);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [7:0]  x;
    logic [15:0] mul, add;
    int          lat;
    bit          hang;
    logic [15:0] res;
    bit          err;
  } tv_t;
  tv_t tv[7];

  logic [15:0] r, r1, r2, r3;
  logic        e;
  bit          rnd_on;

  initial begin
    tv[0] = '{8'h05, 16'd0, 16'h0123, 10, 1'b0, 16'h0123, 1'b0};
    tv[1] = '{8'h03, 16'd2, 16'd0,     4, 1'b0, 16'd6,    1'b0};
    tv[2] = '{8'h07, 16'd2, 16'd0,     1, 1'b0, 16'd14,   1'b0};
    tv[3] = '{8'h09, 16'd2, 16'd0,     2, 1'b0, 16'd18,   1'b0};
    tv[4] = '{8'hFF, 16'd2, 16'd0,     3, 1'b0, 16'h01FE, 1'b0};
    tv[5] = '{8'h80, 16'd3, 16'd1,     5, 1'b0, 16'h0181, 1'b0};
    tv[6] = '{8'h11, 16'd2, 16'd0,     3, 1'b1, 16'h0000, 1'b1};

    rst = 1'b0; in_valid = 1'b0; in_x = '0; out_ready = 1'b1;
    #3;
    chk("rst_in_ready", in_ready, 1);   chk("rst_acc_start", acc_start, 0);
    chk("rst_acc_x", acc_x, 0);         chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0); chk("rst_out_err", out_err, 0);
    chk("rst_busy", busy, 0);           chk("rst_fifo_count", fifo_count, 0);
    @(posedge clk); #1; rst = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Single jobs from an empty FIFO: start latency and result per vector.
    for (int i = 0; i < 7; i++) begin
      mul = tv[i].mul; add = tv[i].add; acc_lat = tv[i].lat; acc_hang = tv[i].hang;
      push(tv[i].x);
      @(negedge clk); chk("lat_cycle_t1", acc_start, 0);
      @(negedge clk); chk("lat_cycle_t2", acc_start, 1);
      get_out(r, e);
      chk("tbl_result", r, tv[i].res);
      chk("tbl_err", e, tv[i].err);
      @(posedge clk); #1;
    end
    acc_hang = 0;

    // Ordering of back-to-back operands.
    mul = 16'd2; add = 16'd0; acc_lat = 5;
    push(8'd3); push(8'd7); push(8'd9);
    get_out(r1, e); get_out(r2, e); get_out(r3, e);
    chk("order_0", r1, 16'd6); chk("order_1", r2, 16'd14); chk("order_2", r3, 16'd18);
    wait_idle();

    // Full FIFO and back-pressure with the consumer stalled.
    mul = 16'd1; add = 16'd0; acc_lat = 3; out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) push(8'(i));
    in_valid = 1'b1; in_x = 8'd6;
    get_out(r, e);
    chk("bp_first_result", r, 16'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_fifo_count", fifo_count, 4);
      chk("bp_no_start", acc_start, 0);
      chk("bp_out_stable", out_result, 16'd1);
      chk("bp_out_valid", out_valid, 1);
    end
    @(posedge clk); #1; out_ready = 1'b1;
    begin
      int n = 0;
      do begin @(negedge clk); n++; end while (!in_ready && n < 200);
      chk("bp_release_bound", n < 200, 1);
    end
    @(posedge clk); #1; in_valid = 1'b0;
    wait_idle();

    // Random traffic with random consumer stalls and accelerator latency.
    mul = 16'd3; add = 16'h0011; rand_lat = 1; rnd_on = 1;
    fork
      begin
        while (rnd_on) begin @(posedge clk); #1; out_ready = ($urandom_range(0, 3) != 0); end
      end
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 6)) @(posedge clk);
          if ($time % 10 != 6) #1;
          push(8'($urandom));
        end
        rnd_on = 0;
      end
    join
    out_ready = 1'b1;
    wait_idle();
    rand_lat = 0;

    // Reset during WAIT_DONE with three operands queued.
    mul = 16'd2; add = 16'd0; acc_lat = 30;
    push(8'd10); push(8'd11); push(8'd12); push(8'd13);
    repeat (4) @(posedge clk); #1;
    chk("mid_fifo_count", fifo_count, 3);
    chk("mid_busy", busy, 1);
    rst = 1'b0; #1;
    chk("mrst_in_ready", in_ready, 1);     chk("mrst_acc_start", acc_start, 0);
    chk("mrst_acc_x", acc_x, 0);           chk("mrst_out_valid", out_valid, 0);
    chk("mrst_out_result", out_result, 0); chk("mrst_out_err", out_err, 0);
    chk("mrst_busy", busy, 0);             chk("mrst_fifo_count", fifo_count, 0);
    @(posedge clk); #1; rst = 1'b1; outv_cnt = 0;
    repeat (60) @(negedge clk);
    chk("post_rst_no_out", outv_cnt, 0);
    chk("post_rst_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
